door_ctrl: RTL and testbench
============================

DOOR_CTRL -- requirements
Module: door_ctrl

Interface
REQ-001 SHALL have parameter ANIM_HOLD, default 6: frame_tick pulses each door animation frame is held.
REQ-002 SHALL have parameter MAX_TRIES, default 3: locked-door clicks allowed before fail (DOOR_TRY_LIMIT_EN only).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port state  input  4  game state: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 SHALL have port key_got  input  1  one-cycle pulse: player picked up the stage key.
REQ-008 SHALL have port door_click  input  1  one-cycle pulse: click inside the door hotspot.
REQ-009 SHALL have port isLocked  output  1  lock sprite select for the door renderer.
REQ-010 SHALL have port door_frame  output  2  door animation frame, 0 closed to 3 fully open.
REQ-011 SHALL have port door_open  output  1  door fully open.
REQ-012 SHALL have port stage_clear  output  1  one-cycle pulse when the open animation completes.
REQ-013 SHALL have port fail_req  output  1  one-cycle pulse on try-limit exhaustion; tied 0 without DOOR_TRY_LIMIT_EN.

Function
REQ-014 SHALL implement FSM states IDLE, LOCKED, UNLOCKED, OPENING, OPEN; all outputs registered.
REQ-015 SHALL treat STAGE1, STAGE2, STAGE3 as active; any other state forces IDLE next cycle.
REQ-016 SHALL go to LOCKED one cycle after state differs from its registered previous value and the new value is active, from any FSM state, clearing hold counter, door_frame and try counter.
REQ-017 In LOCKED, key_got SHALL move to UNLOCKED; isLocked deasserts the following cycle (1-cycle latency).
REQ-018 In UNLOCKED, door_click SHALL move to OPENING with door_frame=0 and hold counter=0; a coincident frame_tick is not counted.
REQ-019 In OPENING, hold counter SHALL increment on frame_tick only; at ANIM_HOLD-1 with frame_tick it wraps to 0 and door_frame increments.
REQ-020 When door_frame=3 and hold counter wraps, SHALL enter OPEN and pulse stage_clear exactly one cycle.
REQ-021 In OPEN, SHALL hold door_frame=3, door_open=1 until a state change per REQ-015/016.
REQ-022 In LOCKED, coincident key_got and door_click: key wins, click discarded.
REQ-023 key_got outside LOCKED and door_click outside LOCKED/UNLOCKED SHALL be ignored.
REQ-024 State change during OPENING SHALL abort without stage_clear.
REQ-025 isLocked SHALL be 1 in IDLE and LOCKED, else 0; door_open 1 only in OPEN.

Reset
REQ-026 rst_n low at a clock edge SHALL force IDLE, isLocked=1, door_frame=0, door_open=0, stage_clear=0, fail_req=0, counters 0, previous-state register=TITLE.
REQ-027 Reset SHALL take priority over all inputs, including mid-OPENING.

Configuration
REQ-028 With DOOR_TRY_LIMIT_EN defined: each door_click in LOCKED (not discarded per REQ-022) increments a try counter; the MAX_TRIES-th click pulses fail_req one cycle, clears the counter, FSM stays LOCKED.
REQ-029 Without DOOR_TRY_LIMIT_EN: no try counter, fail_req constant 0, locked clicks have no effect.

Structure
REQ-030 Game state encodings (TITLE..FAIL) SHALL live in the shared game_defs header, also used by the renderers.
REQ-031 FSM state encodings SHALL be local to door_ctrl.
REQ-032 Hold counter and door_frame advance SHALL be sub-module door_anim_timer (inputs clear, enable, frame_tick; outputs frame, done).

Verification
REQ-033 Reset, then state=2 -> IDLE then LOCKED on successive cycles; isLocked=1, door_frame=0.
REQ-034 LOCKED, key_got pulse, then door_click, ANIM_HOLD=6, frame_tick every 4 cycles -> isLocked=0 next cycle; door_frame 0->1->2->3 every 6 ticks; stage_clear one pulse after 24 ticks; door_open=1.
REQ-035 LOCKED, key_got and door_click same cycle -> UNLOCKED, no OPENING, no try counted.
REQ-036 OPENING at door_frame=2, state 2->4 -> LOCKED, door_frame=0, stage_clear never asserted.
REQ-037 DOOR_TRY_LIMIT_EN, MAX_TRIES=3, three door_click in LOCKED -> fail_req one pulse on third click cycle+1; without macro -> fail_req stays 0.
REQ-038 rst_n low for one cycle during OPENING -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/door_ctrl_pkg.sv
// Shared game definitions: game-state encodings used by door_ctrl and the renderers.
// Optional try limit in door_ctrl is enabled by defining DOOR_TRY_LIMIT_EN.
package door_ctrl_pkg;

  typedef enum logic [3:0] {
    GS_TITLE    = 4'd0,
    GS_STAFF    = 4'd1,
    GS_STAGE1   = 4'd2,
    GS_SUCCESS1 = 4'd3,
    GS_STAGE2   = 4'd4,
    GS_SUCCESS2 = 4'd5,
    GS_STAGE3   = 4'd6,
    GS_SUCCESS3 = 4'd7,
    GS_FAIL     = 4'd8
  } game_state_t;

  localparam logic [1:0] DOOR_FRAME_LAST = 2'd3;

  // Only the playable stages drive the door; menus and results park it.
  function automatic logic is_active_stage(input logic [3:0] gs);
    return (gs == GS_STAGE1) || (gs == GS_STAGE2) || (gs == GS_STAGE3);
  endfunction

endpackage

// File: rtl/door_ctrl_if.sv
// Game-side signal bundle for door_ctrl: game events in, door render controls out.
interface door_ctrl_if;
  logic [3:0] state;
  logic       frame_tick;
  logic       key_got;
  logic       door_click;
  logic       isLocked;
  logic [1:0] door_frame;
  logic       door_open;
  logic       stage_clear;
  logic       fail_req;

  modport master (
    output state, frame_tick, key_got, door_click,
    input  isLocked, door_frame, door_open, stage_clear, fail_req
  );

  modport slave (
    input  state, frame_tick, key_got, door_click,
    output isLocked, door_frame, door_open, stage_clear, fail_req
  );
endinterface

// File: rtl/door_anim_timer.sv
// Door opening animation timer: holds each frame for ANIM_HOLD frame ticks, saturates at the last frame.
module door_anim_timer
  import door_ctrl_pkg::*;
#(
  parameter int ANIM_HOLD = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       frame_tick,
  output logic [1:0] frame,
  output logic       done
);

  localparam int HOLD_W = (ANIM_HOLD > 1) ? $clog2(ANIM_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ANIM_HOLD - 1);

  logic [HOLD_W-1:0] hold_reg;
  logic [1:0]        frame_reg;
  logic              wrap;

  assign wrap  = enable && frame_tick && (hold_reg == HOLD_LAST);
  // done fires on the wrap that would step past the last frame
  assign done  = wrap && (frame_reg == DOOR_FRAME_LAST);
  assign frame = frame_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hold_reg  <= '0;
      frame_reg <= '0;
    end else if (enable && frame_tick) begin
      if (wrap) begin
        hold_reg <= '0;
        if (frame_reg != DOOR_FRAME_LAST) frame_reg <= frame_reg + 2'd1;
      end else begin
        hold_reg <= hold_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/door_ctrl.sv
// Stage exit door controller: lock, key pickup, click-to-open animation, stage clear pulse.
// Define DOOR_TRY_LIMIT_EN to fail the stage after MAX_TRIES clicks on a locked door.
module door_ctrl
  import door_ctrl_pkg::*;
#(
  parameter int ANIM_HOLD = 6,
  parameter int MAX_TRIES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  door_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOCKED, UNLOCKED, OPENING, OPEN} fsm_t;

  fsm_t       fsm_reg;
  logic [3:0] state_prev_reg;
  logic       is_locked_reg;
  logic       door_open_reg;
  logic       stage_clear_reg;
  logic       active;
  logic       changed;
  logic       anim_clear;
  logic       anim_enable;
  logic       anim_done;

  assign active  = is_active_stage(bus.state);
  assign changed = (bus.state != state_prev_reg);

  // Entering, leaving or re-entering a stage and starting a fresh opening all rewind the animation.
  assign anim_clear  = !active || changed || ((fsm_reg == UNLOCKED) && bus.door_click);
  assign anim_enable = (fsm_reg == OPENING);

  door_anim_timer #(.ANIM_HOLD(ANIM_HOLD)) u_anim (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (anim_clear),
    .enable     (anim_enable),
    .frame_tick (bus.frame_tick),
    .frame      (bus.door_frame),
    .done       (anim_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg         <= IDLE;
      state_prev_reg  <= GS_TITLE;
      is_locked_reg   <= 1'b1;
      door_open_reg   <= 1'b0;
      stage_clear_reg <= 1'b0;
    end else begin
      state_prev_reg  <= bus.state;
      stage_clear_reg <= 1'b0;
      if (!active) begin
        fsm_reg       <= IDLE;
        is_locked_reg <= 1'b1;
        door_open_reg <= 1'b0;
      end else if (changed) begin
        fsm_reg       <= LOCKED;
        is_locked_reg <= 1'b1;
        door_open_reg <= 1'b0;
      end else begin
        case (fsm_reg)
          LOCKED: begin
            if (bus.key_got) begin
              fsm_reg       <= UNLOCKED;
              is_locked_reg <= 1'b0;
            end
          end
          UNLOCKED: begin
            if (bus.door_click) fsm_reg <= OPENING;
          end
          OPENING: begin
            if (anim_done) begin
              fsm_reg         <= OPEN;
              door_open_reg   <= 1'b1;
              stage_clear_reg <= 1'b1;
            end
          end
          default: fsm_reg <= fsm_reg;
        endcase
      end
    end
  end

  assign bus.isLocked    = is_locked_reg;
  assign bus.door_open   = door_open_reg;
  assign bus.stage_clear = stage_clear_reg;

`ifdef DOOR_TRY_LIMIT_EN
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  logic [TRY_W-1:0] tries_reg;
  logic             fail_req_reg;
  logic             locked_click;

  // A click coinciding with the key pickup is spent on the key, not counted.
  assign locked_click = (fsm_reg == LOCKED) && active && !changed
                        && bus.door_click && !bus.key_got;

  always_ff @(posedge clk) begin
    if (!rst_n || !active || changed) begin
      tries_reg    <= '0;
      fail_req_reg <= 1'b0;
    end else begin
      fail_req_reg <= 1'b0;
      if (locked_click) begin
        if (tries_reg == TRY_LAST) begin
          tries_reg    <= '0;
          fail_req_reg <= 1'b1;
        end else begin
          tries_reg <= tries_reg + 1'b1;
        end
      end
    end
  end

  assign bus.fail_req = fail_req_reg;
`else
  // MAX_TRIES has no effect in this build; referenced only to keep it a used parameter.
  assign bus.fail_req = 1'b0 & (MAX_TRIES > 0);
`endif

endmodule

// File: tb/tb_door_ctrl.sv
// Scoreboard bench for door_ctrl: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_door_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  door_ctrl_if bus ();

  door_ctrl #(.ANIM_HOLD(6), .MAX_TRIES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef DOOR_TRY_LIMIT_EN
  localparam logic TRY_EN = 1'b1;
`else
  localparam logic TRY_EN = 1'b0;
`endif

  typedef struct {
    string      name;
    int         cyc;
    logic       il;
    logic [1:0] fr;
    logic       op;
    logic       sc;
    logic       fl;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (e.cyc != cyc || bus.isLocked !== e.il || bus.door_frame !== e.fr ||
          bus.door_open !== e.op || bus.stage_clear !== e.sc || bus.fail_req !== e.fl) begin
        miscompares++;
        $display("FAIL %s cyc=%0d/%0d got il=%b fr=%0d open=%b clr=%b fail=%b want il=%b fr=%0d open=%b clr=%b fail=%b",
                 e.name, cyc, e.cyc, bus.isLocked, bus.door_frame, bus.door_open,
                 bus.stage_clear, bus.fail_req, e.il, e.fr, e.op, e.sc, e.fl);
      end
    end
  end

  task automatic drive(input logic [3:0] st, input logic ft, input logic kg, input logic dc,
                       input string nm, input logic il, input logic [1:0] fr,
                       input logic op, input logic sc, input logic fl);
    exp_t e;
    bus.state      = st;
    bus.frame_tick = ft;
    bus.key_got    = kg;
    bus.door_click = dc;
    e.name = nm; e.cyc = cyc + 1;
    e.il = il; e.fr = fr; e.op = op; e.sc = sc; e.fl = fl;
    sb.push_back(e);
    $display("vec %-20s cyc=%0d st=%0d tick=%b key=%b click=%b", nm, cyc + 1, st, ft, kg, dc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.state = 4'd0; bus.frame_tick = 1'b0; bus.key_got = 1'b0; bus.door_click = 1'b0;

    rst_n = 1'b0;
    drive(4'd0, 0, 1, 0, "reset",            1, 2'd0, 0, 0, 0);
    drive(4'd0, 0, 1, 1, "reset_hold",       1, 2'd0, 0, 0, 0);
    rst_n = 1'b1;
    drive(4'd0, 0, 1, 0, "idle_key_ignored", 1, 2'd0, 0, 0, 0);
    drive(4'd2, 0, 0, 0, "enter_locked",     1, 2'd0, 0, 0, 0);
    drive(4'd2, 0, 1, 0, "key_unlock",       0, 2'd0, 0, 0, 0);
    drive(4'd2, 1, 0, 1, "click_opening",    0, 2'd0, 0, 0, 0);

    // 24 ticks, one every 4 cycles; frame steps every 6 ticks, clear on tick 24
    for (int k = 1; k <= 24; k++) begin
      for (int j = 0; j < 4; j++) begin
        logic [1:0] fr;
        fr = (k >= 18) ? 2'd3 : 2'(k / 6);
        drive(4'd2, (j == 0), 0, 0, "anim_run", 0, fr, (k == 24), (k == 24 && j == 0), 0);
      end
    end
    drive(4'd2, 1, 1, 1, "open_ignores_inputs", 0, 2'd3, 1, 0, 0);
    drive(4'd2, 1, 0, 0, "open_hold",           0, 2'd3, 1, 0, 0);
    drive(4'd8, 0, 0, 0, "fail_state_idle",     1, 2'd0, 0, 0, 0);
    drive(4'd2, 0, 0, 0, "relock",              1, 2'd0, 0, 0, 0);
    drive(4'd2, 0, 1, 1, "key_beats_click",     0, 2'd0, 0, 0, 0);
    for (int k = 0; k < 7; k++)
      drive(4'd2, 1, 0, 0, "no_opening", 0, 2'd0, 0, 0, 0);

    drive(4'd2, 0, 0, 1, "click_opening2", 0, 2'd0, 0, 0, 0);
    for (int k = 1; k <= 12; k++)
      drive(4'd2, 1, 0, 0, "opening_frame", 0, 2'(k / 6), 0, 0, 0);
    drive(4'd4, 1, 0, 0, "abort_relock", 1, 2'd0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      drive(4'd4, 1, 0, 0, "abort_no_clear", 1, 2'd0, 0, 0, 0);

    drive(4'd4, 0, 0, 1, "try1",            1, 2'd0, 0, 0, 0);
    drive(4'd4, 0, 0, 0, "try_gap",         1, 2'd0, 0, 0, 0);
    drive(4'd4, 0, 0, 1, "try2",            1, 2'd0, 0, 0, 0);
    drive(4'd4, 0, 0, 1, "try3_fail",       1, 2'd0, 0, 0, TRY_EN);
    drive(4'd4, 0, 0, 0, "fail_pulse_end",  1, 2'd0, 0, 0, 0);
    drive(4'd4, 0, 0, 1, "try_after_clear", 1, 2'd0, 0, 0, 0);

    drive(4'd4, 0, 1, 0, "key_unlock2",    0, 2'd0, 0, 0, 0);
    drive(4'd4, 0, 0, 1, "click_opening3", 0, 2'd0, 0, 0, 0);
    for (int k = 1; k <= 6; k++)
      drive(4'd4, 1, 0, 0, "opening_frame2", 0, 2'(k / 6), 0, 0, 0);
    rst_n = 1'b0;
    drive(4'd4, 1, 0, 0, "reset_mid_open",    1, 2'd0, 0, 0, 0);
    rst_n = 1'b1;
    drive(4'd4, 1, 0, 0, "post_reset_locked", 1, 2'd0, 0, 0, 0);
    drive(4'd4, 0, 1, 0, "key_unlock3",       0, 2'd0, 0, 0, 0);
    drive(4'd0, 0, 0, 0, "title_idle",        1, 2'd0, 0, 0, 0);

    bus.frame_tick = 1'b0; bus.key_got = 1'b0; bus.door_click = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      vectors += sb.size();
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
